// File: rtl/track_occupancy_detector_if.sv
// Sensor inputs and status outputs of the track occupancy detector.
// master drives the raw treadles; slave is the detector itself.
interface track_occupancy_detector_if #(
    parameter int CNT_W = 4
);
    logic             sens_in;
    logic             sens_out;
    logic             present;
    logic [CNT_W-1:0] occ_count;
    logic             wrong_dir;
    logic             fault;

    modport master (
        output sens_in, sens_out,
        input  present, occ_count, wrong_dir, fault
    );

    modport slave (
        input  sens_in, sens_out,
        output present, occ_count, wrong_dir, fault
    );
endinterface

// File: rtl/track_occupancy_detector.sv
// Track occupancy detector: synchronises and debounces the approach/exit treadles, counts
// trains in the section and holds the crossing request until the section has stayed clear.
module track_occupancy_detector #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 4,
    parameter int CLEAR_HOLD = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                      clk,
    input  logic                      reset,
    track_occupancy_detector_if.slave bus
);

    localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_W   = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;
    localparam int SETTLE   = DEB_CYCLES + 3;
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, OCCUPIED, CLEARING, FAULT} state_t;

    // Bit 0 is the approach sensor, bit 1 the exit sensor.
    logic [1:0]          raw;
    logic [1:0]          sync1;
    logic [1:0]          sync2;
    logic [1:0]          filt;
    logic [1:0]          filt_d;
    logic [1:0]          rise;
    logic [DEB_W-1:0]    deb_cnt [2];
    logic [SETTLE_W-1:0] settle_cnt;
    logic                armed;
    logic                enter_ev;
    logic                exit_ev;
    logic                inc;
    logic                dec;
    logic                overflow;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    occ_q;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [IDLE_W-1:0]   idle_t;
    logic [IDLE_W-1:0]   idle_nxt;
    logic [HOLD_W-1:0]   hold_t;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                wrong_nxt;
    logic                wrong_q;
    logic                present_q;
    logic                fault_q;

    assign raw = {bus.sens_out, bus.sens_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            filt       <= '0;
            filt_d     <= '0;
            settle_cnt <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            sync1  <= raw;
            sync2  <= sync1;
            filt_d <= filt;
            if (settle_cnt != SETTLE_W'(SETTLE)) settle_cnt <= settle_cnt + 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    filt[i]    <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A filter that first settles high straight after reset is not a train arriving,
    // so edges are ignored until a held-high sensor would have been filtered.
    assign armed    = (settle_cnt == SETTLE_W'(SETTLE));
    assign rise     = filt & ~filt_d & {2{armed}};
    assign enter_ev = rise[0];
    assign exit_ev  = rise[1];
    assign inc      = enter_ev & ~exit_ev;
    assign dec      = exit_ev & ~enter_ev;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave a latch behind.
        state_nxt = state;
        cnt_nxt   = occ_q;
        idle_nxt  = idle_t;
        hold_nxt  = hold_t;
        wrong_nxt = 1'b0;
        overflow  = 1'b0;

        // Coincident enter and exit cancel out; the count saturates at both ends.
        if (inc) begin
            if (occ_q == CNT_MAX) overflow = 1'b1;
            else                  cnt_nxt  = occ_q + 1'b1;
        end else if (dec) begin
            if (occ_q == '0) wrong_nxt = 1'b1;
            else             cnt_nxt   = occ_q - 1'b1;
        end

        case (state)
            IDLE: begin
                if (inc) begin
                    state_nxt = OCCUPIED;
                    idle_nxt  = '0;
                end
            end
            OCCUPIED: begin
                if (overflow) begin
                    state_nxt = FAULT;
                end else if (dec && occ_q == CNT_W'(1)) begin
                    state_nxt = CLEARING;
                    hold_nxt  = '0;
                end else if (enter_ev || exit_ev) begin
                    idle_nxt  = '0;
                end else if (idle_t == IDLE_W'(TIMEOUT - 1)) begin
                    state_nxt = FAULT;
                end else begin
                    idle_nxt  = idle_t + 1'b1;
                end
            end
            CLEARING: begin
                if (inc) begin
                    state_nxt = OCCUPIED;
                    idle_nxt  = '0;
                    hold_nxt  = '0;
                end else if (hold_t == HOLD_W'(CLEAR_HOLD - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt  = hold_t + 1'b1;
                end
            end
            default: begin
                // FAULT keeps the crossing closed until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            occ_q     <= '0;
            idle_t    <= '0;
            hold_t    <= '0;
            wrong_q   <= 1'b0;
            present_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            occ_q     <= cnt_nxt;
            idle_t    <= idle_nxt;
            hold_t    <= hold_nxt;
            wrong_q   <= wrong_nxt;
            present_q <= (state_nxt != IDLE);
            fault_q   <= (state_nxt == FAULT);
        end
    end

    assign bus.present   = present_q;
    assign bus.occ_count = occ_q;
    assign bus.wrong_dir = wrong_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_track_occupancy_detector.sv
// Testbench for track_occupancy_detector: directed scenarios plus random treadle traffic,
// scored every cycle against a behavioural model of the section.
module tb_track_occupancy_detector;

    localparam int DEB   = 4;
    localparam int CNT_W = 4;
    localparam int CH    = 8;
    localparam int TO    = 200;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    track_occupancy_detector_if #(.CNT_W(CNT_W)) bus ();

    track_occupancy_detector #(
        .DEB_CYCLES(DEB),
        .CNT_W     (CNT_W),
        .CLEAR_HOLD(CH),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             present;
        logic [CNT_W-1:0] cnt;
        logic             wrong_dir;
        logic             fault;
    } exp_t;

    typedef enum {M_IDLE, M_OCC, M_CLR, M_FLT} mstate_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    mstate_t     m_state;
    int          m_cnt;
    int          m_idle;
    int          m_hold;
    int          m_edges;
    bit [1:0]    m_filt;
    bit [1:0]    m_pend;
    logic [63:0] m_hist [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a filtered sensor flips once its last DEB synchronised samples
    // (raw samples two edges old) all disagree with it; rising flips become events next cycle.
    always @(posedge clk) begin
        exp_t     e;
        bit       en;
        bit       ex;
        bit       wd;
        bit       flip;
        int       delta;
        bit [1:0] raw_now;
        bit [1:0] rise;
        raw_now = {bus.sens_out, bus.sens_in};
        wd      = 1'b0;
        rise    = 2'b00;
        if (!reset) begin
            m_state   = M_IDLE;
            m_cnt     = 0;
            m_idle    = 0;
            m_hold    = 0;
            m_edges   = 0;
            m_filt    = 2'b00;
            m_pend    = 2'b00;
            m_hist[0] = '0;
            m_hist[1] = '0;
        end else begin
            en    = m_pend[0];
            ex    = m_pend[1];
            delta = int'(en) - int'(ex);
            case (m_state)
                M_IDLE: begin
                    if (delta > 0) begin
                        m_state = M_OCC;
                        m_cnt   = 1;
                        m_idle  = 0;
                    end else if (delta < 0) begin
                        wd = 1'b1;
                    end
                end
                M_OCC: begin
                    if (delta > 0 && m_cnt == MAXC) begin
                        m_state = M_FLT;
                    end else begin
                        m_cnt = m_cnt + delta;
                        if (m_cnt == 0) begin
                            m_state = M_CLR;
                            m_hold  = 0;
                        end else if (en || ex) begin
                            m_idle = 0;
                        end else if (m_idle == TO - 1) begin
                            m_state = M_FLT;
                        end else begin
                            m_idle++;
                        end
                    end
                end
                M_CLR: begin
                    if (delta > 0) begin
                        m_state = M_OCC;
                        m_cnt   = 1;
                        m_idle  = 0;
                        m_hold  = 0;
                    end else begin
                        if (delta < 0) wd = 1'b1;
                        if (m_hold == CH - 1) m_state = M_IDLE;
                        else                  m_hold++;
                    end
                end
                default: begin
                    if (delta > 0 && m_cnt < MAXC) m_cnt++;
                    else if (delta < 0) begin
                        if (m_cnt == 0) wd = 1'b1;
                        else            m_cnt--;
                    end
                end
            endcase

            if (m_edges < 1000) m_edges++;
            for (int s = 0; s < 2; s++) begin
                m_hist[s] = {m_hist[s][62:0], raw_now[s]};
                flip = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (m_hist[s][2+k] == m_filt[s]) flip = 1'b0;
                if (flip) begin
                    m_filt[s] = ~m_filt[s];
                    rise[s]   = m_filt[s] && (m_edges >= DEB + 3);
                end
            end
            m_pend = rise;
        end
        e.present   = (m_state != M_IDLE);
        e.cnt       = m_cnt[CNT_W-1:0];
        e.wrong_dir = wd;
        e.fault     = (m_state == M_FLT);
        exp_q.push_back(e);
    end

    // Monitor: outputs settle after the rising edge and are compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("present",   bus.present,   e.present);
            check("occ_count", bus.occ_count, e.cnt);
            check("wrong_dir", bus.wrong_dir, e.wrong_dir);
            check("fault",     bus.fault,     e.fault);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_in(input int hi, input int lo);
        bus.sens_in = 1'b1;
        wait_cycles(hi);
        bus.sens_in = 1'b0;
        wait_cycles(lo);
    endtask

    task automatic pulse_out(input int hi, input int lo);
        bus.sens_out = 1'b1;
        wait_cycles(hi);
        bus.sens_out = 1'b0;
        wait_cycles(lo);
    endtask

    // Reset asserted between edges must clear the outputs without waiting for a clock.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check({tag, "_rst_present"}, bus.present, 0);
        check({tag, "_rst_count"},   bus.occ_count, 0);
        check({tag, "_rst_fault"},   bus.fault, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    int wd_seen;

    initial begin
        bus.sens_in  = 1'b0;
        bus.sens_out = 1'b0;
        reset        = 1'b0;
        wait_cycles(3);
        check("reset_present", bus.present, 0);
        check("reset_count",   bus.occ_count, 0);
        #2 reset = 1'b1;
        wait_cycles(10);

        // Single train with exact latency and clearing hold.
        bus.sens_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("t1_lat_edge6", bus.present, 0);
        @(posedge clk);
        #1 check("t1_lat_edge7", bus.present, 1);
        check("t1_count1", bus.occ_count, 1);
        repeat (3) @(negedge clk);
        bus.sens_in = 1'b0;
        wait_cycles(30);
        bus.sens_out = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 7)  check("t1_count0", bus.occ_count, 0);
            if (i == 10) bus.sens_out = 1'b0;
            if (i == 14) check("t1_hold_edge14", bus.present, 1);
            if (i == 15) check("t1_hold_edge15", bus.present, 0);
        end
        @(negedge clk);
        wait_cycles(10);

        // Glitches shorter than the debounce window.
        for (int i = 0; i < 5; i++) pulse_in(3, 3);
        wait_cycles(10);
        check("t2_count", bus.occ_count, 0);
        check("t2_present", bus.present, 0);

        // Back-to-back trains, then coincident enter/exit.
        pulse_in(10, 10);
        pulse_in(10, 10);
        check("t3_count2", bus.occ_count, 2);
        pulse_out(10, 10);
        check("t3_count1", bus.occ_count, 1);
        bus.sens_in  = 1'b1;
        bus.sens_out = 1'b1;
        wait_cycles(10);
        bus.sens_in  = 1'b0;
        bus.sens_out = 1'b0;
        wait_cycles(10);
        check("t3_coincident", bus.occ_count, 1);
        pulse_out(10, 20);
        check("t3_idle", bus.present, 0);

        // Wrong direction in IDLE.
        wd_seen = 0;
        bus.sens_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 9) bus.sens_out = 1'b0;
            wd_seen += int'(bus.wrong_dir);
        end
        check("t4_wd_idle", wd_seen, 1);
        check("t4_idle_present", bus.present, 0);
        wait_cycles(10);

        // Wrong direction on the last CLEARING cycle; hold expiry unchanged.
        pulse_in(10, 20);
        wd_seen = 0;
        bus.sens_out = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 4)  bus.sens_out = 1'b0;
            if (j == 8)  bus.sens_out = 1'b1;
            if (j == 18) bus.sens_out = 1'b0;
            wd_seen += int'(bus.wrong_dir);
            if (j == 14) check("t4_clr_edge14", bus.present, 1);
            if (j == 15) check("t4_clr_edge15", bus.present, 0);
        end
        check("t4_wd_clearing", wd_seen, 1);
        wait_cycles(10);

        // Occupancy timeout, exit while faulted, then reset.
        pulse_in(10, 10);
        wait_cycles(200);
        check("t5_timeout_fault", bus.fault, 1);
        check("t5_timeout_present", bus.present, 1);
        pulse_out(10, 10);
        check("t5_fault_count", bus.occ_count, 0);
        check("t5_fault_sticky", bus.fault, 1);
        check("t5_fault_present", bus.present, 1);
        reset_pulse("t5");
        wait_cycles(10);

        // Counter overflow.
        for (int i = 0; i < 16; i++) pulse_in(5, 5);
        wait_cycles(10);
        check("t5_ovf_count", bus.occ_count, MAXC);
        check("t5_ovf_fault", bus.fault, 1);
        reset_pulse("t5ovf");
        wait_cycles(10);

        // Re-entry three cycles into CLEARING.
        pulse_in(10, 10);
        bus.sens_out = 1'b1;
        wait_cycles(3);
        bus.sens_in = 1'b1;
        wait_cycles(7);
        bus.sens_out = 1'b0;
        wait_cycles(3);
        bus.sens_in = 1'b0;
        wait_cycles(7);
        check("t6_reentry_count", bus.occ_count, 1);
        check("t6_reentry_present", bus.present, 1);

        // Reset mid-OCCUPIED with the approach sensor held high across release.
        bus.sens_in = 1'b1;
        wait_cycles(12);
        check("t6_count2", bus.occ_count, 2);
        reset_pulse("t6");
        wait_cycles(20);
        check("t6_held_present", bus.present, 0);
        check("t6_held_count", bus.occ_count, 0);
        bus.sens_in = 1'b0;
        wait_cycles(10);

        // Random treadle traffic with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            bus.sens_in  = ($urandom_range(0, 2) == 0);
            bus.sens_out = ($urandom_range(0, 3) == 0);
            wait_cycles($urandom_range(1, 14));
            if (seg % 80 == 79) reset_pulse("rand");
        end
        bus.sens_in  = 1'b0;
        bus.sens_out = 1'b0;
        wait_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
